// File: rtl/ex_mem_flag_stage_pkg.sv
// Shared constants for the EX/MEM flag stage: condition codes, flag bit
// positions within the {Z,N,V} write-enable vector, and common enables.
package ex_mem_flag_stage_pkg;

  localparam logic [2:0] CC_NE  = 3'b000;
  localparam logic [2:0] CC_EQ  = 3'b001;
  localparam logic [2:0] CC_GT  = 3'b010;
  localparam logic [2:0] CC_LT  = 3'b011;
  localparam logic [2:0] CC_GE  = 3'b100;
  localparam logic [2:0] CC_LE  = 3'b101;
  localparam logic [2:0] CC_OV  = 3'b110;
  localparam logic [2:0] CC_UNC = 3'b111;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [2:0] WE_ALL  = 3'b111;
  localparam logic [2:0] WE_Z    = 3'b100;
  localparam logic [2:0] WE_NONE = 3'b000;

endpackage

// File: rtl/branch_cond_eval.sv
// Pure combinational decode of a 3-bit condition code against the
// effective Z/N/V flags.
module branch_cond_eval
  import ex_mem_flag_stage_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       z,
  input  logic       n,
  input  logic       v,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      CC_NE:   taken = ~z;
      CC_EQ:   taken = z;
      CC_GT:   taken = ~z & ~n;
      CC_LT:   taken = n;
      CC_GE:   taken = z | ~n;
      CC_LE:   taken = z | n;
      CC_OV:   taken = v;
      CC_UNC:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with the architectural Z/N/V flags, sticky
// overflow and flag-bypassed branch condition evaluation.
module ex_mem_flag_stage
  import ex_mem_flag_stage_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_result,
  input  logic [DW-1:0] ex_store_data,
  input  logic [RW-1:0] ex_dst,
  input  logic          ex_regwrite,
  input  logic          ex_memread,
  input  logic          ex_memwrite,
  input  logic          ex_zr,
  input  logic          ex_neg,
  input  logic          ex_ov,
  input  logic [2:0]    ex_flag_we,
  input  logic [2:0]    br_cond,
  input  logic          clr_sticky,
  output logic          mem_valid,
  output logic          mem_regwrite,
  output logic          mem_memread,
  output logic          mem_memwrite,
  output logic [DW-1:0] mem_result,
  output logic [DW-1:0] mem_store_data,
  output logic [RW-1:0] mem_dst,
  output logic          flag_z,
  output logic          flag_n,
  output logic          flag_v,
  output logic          br_taken,
  output logic          ov_sticky
);

  logic       advance;
  logic [2:0] flag_upd;
  logic       eff_z, eff_n, eff_v;

  assign advance  = ~stall & ~flush;
  assign flag_upd = (advance & ex_valid) ? ex_flag_we : WE_NONE;

  // Flags written by the instruction in EX are forwarded to the branch unit
  // in the same cycle they are being captured.
  assign eff_z = flag_upd[FLAG_Z] ? ex_zr  : flag_z;
  assign eff_n = flag_upd[FLAG_N] ? ex_neg : flag_n;
  assign eff_v = flag_upd[FLAG_V] ? ex_ov  : flag_v;

  branch_cond_eval u_branch_cond_eval (
    .cond  (br_cond),
    .z     (eff_z),
    .n     (eff_n),
    .v     (eff_v),
    .taken (br_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_regwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_result     <= '0;
      mem_store_data <= '0;
      mem_dst        <= '0;
      flag_z         <= 1'b0;
      flag_n         <= 1'b0;
      flag_v         <= 1'b0;
      ov_sticky      <= 1'b0;
    end else begin
      if (flush) begin
        mem_valid      <= 1'b0;
        mem_regwrite   <= 1'b0;
        mem_memread    <= 1'b0;
        mem_memwrite   <= 1'b0;
        mem_result     <= '0;
        mem_store_data <= '0;
        mem_dst        <= '0;
      end else if (!stall) begin
        mem_valid      <= ex_valid;
        mem_regwrite   <= ex_regwrite & ex_valid;
        mem_memread    <= ex_memread & ex_valid;
        mem_memwrite   <= ex_memwrite & ex_valid;
        mem_result     <= ex_result;
        mem_store_data <= ex_store_data;
        mem_dst        <= ex_dst;
      end

      if (flag_upd[FLAG_Z]) flag_z <= ex_zr;
      if (flag_upd[FLAG_N]) flag_n <= ex_neg;
      if (flag_upd[FLAG_V]) flag_v <= ex_ov;

      // Set has priority over a coincident clear.
      if (flag_upd[FLAG_V] & ex_ov) begin
        ov_sticky <= 1'b1;
      end else if (clr_sticky) begin
        ov_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ex_mem_flag_stage.md
Name: ex_mem_flag_stage

Overview:
- Sits directly downstream of the 16-bit saturating adder in EX.
- Latches the EX result and its control into the EX/MEM pipeline register.
- Holds the architectural Z/N/V flag register, fed from the adder's zr/neg/ov outputs.
- Evaluates 3-bit branch conditions against the flags for the branch unit, plus a sticky overflow bit for software/debug.

Parameters:
- DW, 16, datapath width.
- RW, 4, register-file address width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold EX/MEM register and flags
- flush  in  1  kill the instruction currently in EX
- ex_valid  in  1  EX holds a real instruction
- ex_result  in  DW  ALU/adder result
- ex_store_data  in  DW  store data
- ex_dst  in  RW  destination register
- ex_regwrite  in  1  write-back enable
- ex_memread  in  1  load
- ex_memwrite  in  1  store
- ex_zr, ex_neg, ex_ov  in  1 each  flags from adder/ALU
- ex_flag_we  in  3  per-flag write enable {Z,N,V}; bit2=Z, bit1=N, bit0=V
- br_cond  in  3  condition code
- clr_sticky  in  1  clear sticky overflow
- mem_valid, mem_regwrite, mem_memread, mem_memwrite  out  1 each  registered control
- mem_result, mem_store_data  out  DW  registered data
- mem_dst  out  RW  registered destination
- flag_z, flag_n, flag_v  out  1 each  registered flags
- br_taken  out  1  combinational condition result
- ov_sticky  out  1  sticky overflow

Behaviour:
- Reset (rst=1 at edge):
  - All mem_* outputs go to 0.
  - Flags go to 0.
  - ov_sticky goes to 0.
  - rst overrides stall, flush and clr_sticky.
- Capture condition: advance = ~stall & ~flush.
- Pipeline register:
  - When advance, all mem_* load the ex_* values next edge, with mem_valid=ex_valid.
  - Control bits (regwrite/memread/memwrite) are ANDed with ex_valid before capture.
  - Latency: 1 cycle.
- Flush:
  - flush=1 (regardless of stall) loads a bubble: mem_valid=0 and mem_regwrite/memread/memwrite=0.
  - Data fields under flush: don't-care, but must be driven to 0.
  - Flags and ov_sticky are unchanged.
- Stall with flush=0: all mem_* and flags hold.
- Flags:
  - On advance & ex_valid, each flag whose ex_flag_we bit is set loads its ex_* value next edge.
  - Unselected flags hold.
  - ADD/SUB use we=111; logical ops use we=100; other ops use 000.
- Sticky overflow:
  - Set next edge when advance & ex_valid & ex_flag_we[0] & ex_ov.
  - Cleared by clr_sticky.
  - Simultaneous set and clear: set wins.
- Branch evaluation (combinational) uses effective flags Z', N', V'.
  - If advance & ex_valid & ex_flag_we[i], the effective flag is the incoming ex_* bit (bypass); otherwise it is the registered flag.
  - Conditions:
    - 000 NE: ~Z'
    - 001 EQ: Z'
    - 010 GT: ~Z' & ~N'
    - 011 LT: N'
    - 100 GE: Z' | ~N'
    - 101 LE: Z' | N'
    - 110 OV: V'
    - 111 always 1
- Saturation interplay:
  - When the adder saturates positive it reports neg=1, ov=1.
  - The block stores those values exactly as given and performs no re-derivation from ex_result.
- br_taken has no registered state; the branch/hazard unit owns the timing.

Decomposition:
- Shared package holds:
  - condition-code constants (CC_NE..CC_UNC)
  - flag-index constants (FLAG_Z=2, FLAG_N=1, FLAG_V=0)
  - write-enable constants WE_ALL=3'b111, WE_Z=3'b100, WE_NONE=3'b000
- One natural sub-module, branch_cond_eval: purely combinational mapping of (br_cond, Z', N', V') to br_taken. Bypass muxing stays in the parent.

Test Plan:
- Reset: rst=1 for 2 cycles with all inputs toggling -> all outputs 0 and br_taken for cond 000 equals 1.
- Advance: ex_valid=1, result=16'h1234, dst=4'h5, regwrite=1, we=111, zr=0, neg=0, ov=0 -> next cycle mem_result=1234, mem_dst=5, mem_regwrite=1, flags 000; with br_cond=010, br_taken=1.
- Saturation and partial write:
  - Adder saturating input (result 7FFF, neg=1, ov=1, we=111) -> flag_n=1, flag_v=1, ov_sticky=1; br_cond=110 -> 1.
  - Then a we=100 op with zr=1 -> only flag_z changes to 1; flag_n and flag_v stay 1.
- Stall/flush:
  - stall=1 for 3 cycles with changing ex_* -> mem_* and flags frozen.
  - stall=1 & flush=1 -> bubble: mem_valid=0, mem_regwrite=0; flags unchanged.
  - ex_valid=0 with regwrite=1 -> mem_regwrite=0.
- Bypass: registered Z=0, same cycle ex_zr=1, we=100, advance, br_cond=001 -> br_taken=1 that cycle. Repeat with stall=1 -> br_taken=0.
- Sticky: clr_sticky=1 coincident with an overflowing ADD -> ov_sticky stays 1. Next cycle clr_sticky alone -> ov_sticky=0.
